// File: rtl/cc_pkg.sv
// cc_pkg: shared cache-controller widths and the decoded request type.
package cc_pkg;
    localparam int TAG_W = 17;
    localparam int IDX_W = 9;
    localparam int OFS_W = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFS_W-1:0] offset;
    } cc_req_t;
endpackage

// File: rtl/cc_tag_ram.sv
// cc_tag_ram: single-clock tag RAM, registered read, old data on read-during-write.
module cc_tag_ram #(
    parameter int AW = 9,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [1<<AW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/cc_tag_lookup.sv
// cc_tag_lookup: two-stage tag check with fill forwarding and hit/miss pushes.
// Optional hit/miss statistics counters are enabled by defining CC_TAG_STAT_EN.
module cc_tag_lookup #(
    parameter int TAG_W = cc_pkg::TAG_W,
    parameter int IDX_W = cc_pkg::IDX_W,
    parameter int OFS_W = cc_pkg::OFS_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hs_pulse_i,
    input  logic [TAG_W-1:0]             tag_i,
    input  logic [IDX_W-1:0]             index_i,
    input  logic [OFS_W-1:0]             offset_i,
    input  logic                         fill_valid_i,
    input  logic [IDX_W-1:0]             fill_index_i,
    input  logic [TAG_W-1:0]             fill_tag_i,
    output logic                         hit_flag_wren_o,
    output logic                         hit_flag_wdata_o,
    output logic                         miss_addr_wren_o,
    output logic [TAG_W+IDX_W+OFS_W-1:0] miss_addr_wdata_o,
    output logic                         miss_req_wren_o,
    output logic [TAG_W+IDX_W-1:0]       miss_req_wdata_o,
    output logic                         data_rden_o,
    output logic [IDX_W-1:0]             data_index_o,
    output logic [OFS_W-1:0]             data_offset_o,
    output logic [31:0]                  hit_cnt_o,
    output logic [31:0]                  miss_cnt_o
);
    import cc_pkg::*;

    logic                   r_s1_v;
    cc_req_t                r_s1;
    logic [(1<<IDX_W)-1:0]  r_valid;
    logic                   r_fill_v;
    logic [IDX_W-1:0]       r_fill_idx;
    logic [TAG_W-1:0]       r_fill_tag;
    logic [TAG_W-1:0]       w_ram_q;
    logic                   w_fwd_now;
    logic                   w_fwd_prev;
    logic [TAG_W-1:0]       w_cmp_tag;
    logic                   w_vld;
    logic                   w_hit;
    logic                   w_miss;

    cc_tag_ram #(.AW(IDX_W), .DW(TAG_W)) u_ram (
        .clk     (clk),
        .i_we    (fill_valid_i),
        .i_waddr (fill_index_i),
        .i_wdata (fill_tag_i),
        .i_raddr (index_i),
        .o_rdata (w_ram_q)
    );

    // A fill in the compare cycle beats one from the read cycle, which the RAM missed.
    always_comb begin
        w_fwd_now  = fill_valid_i && (fill_index_i == r_s1.index);
        w_fwd_prev = r_fill_v && (r_fill_idx == r_s1.index);
        w_cmp_tag  = w_fwd_now ? fill_tag_i : (w_fwd_prev ? r_fill_tag : w_ram_q);
        w_vld      = w_fwd_now | r_valid[r_s1.index];
        w_hit      = r_s1_v & w_vld & (w_cmp_tag == r_s1.tag);
        w_miss     = r_s1_v & ~w_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v            <= 1'b0;
            r_s1              <= '0;
            r_valid           <= '0;
            r_fill_v          <= 1'b0;
            r_fill_idx        <= '0;
            r_fill_tag        <= '0;
            hit_flag_wren_o   <= 1'b0;
            hit_flag_wdata_o  <= 1'b0;
            miss_addr_wren_o  <= 1'b0;
            miss_addr_wdata_o <= '0;
            miss_req_wren_o   <= 1'b0;
            miss_req_wdata_o  <= '0;
            data_rden_o       <= 1'b0;
            data_index_o      <= '0;
            data_offset_o     <= '0;
        end else begin
            r_s1_v     <= hs_pulse_i;
            if (hs_pulse_i) r_s1 <= '{tag: tag_i, index: index_i, offset: offset_i};
            r_fill_v   <= fill_valid_i;
            r_fill_idx <= fill_index_i;
            r_fill_tag <= fill_tag_i;
            if (fill_valid_i) r_valid[fill_index_i] <= 1'b1;
            hit_flag_wren_o  <= r_s1_v;
            hit_flag_wdata_o <= w_hit;
            miss_addr_wren_o <= w_miss;
            miss_req_wren_o  <= w_miss;
            data_rden_o      <= w_hit;
            if (r_s1_v) begin
                miss_addr_wdata_o <= r_s1;
                miss_req_wdata_o  <= {r_s1.tag, r_s1.index};
                data_index_o      <= r_s1.index;
                data_offset_o     <= r_s1.offset;
            end
        end
    end

`ifdef CC_TAG_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cc_tag_lookup.sv
// tb_cc_tag_lookup: directed checks of lookup, fill forwarding, reset and counters.
module tb_cc_tag_lookup;
    logic        clk = 1'b0;
    logic        rst;
    logic        hs_pulse_i;
    logic [16:0] tag_i;
    logic [8:0]  index_i;
    logic [2:0]  offset_i;
    logic        fill_valid_i;
    logic [8:0]  fill_index_i;
    logic [16:0] fill_tag_i;
    logic        hit_flag_wren_o;
    logic        hit_flag_wdata_o;
    logic        miss_addr_wren_o;
    logic [28:0] miss_addr_wdata_o;
    logic        miss_req_wren_o;
    logic [25:0] miss_req_wdata_o;
    logic        data_rden_o;
    logic [8:0]  data_index_o;
    logic [2:0]  data_offset_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cc_tag_lookup dut (
        .clk               (clk),
        .rst               (rst),
        .hs_pulse_i        (hs_pulse_i),
        .tag_i             (tag_i),
        .index_i           (index_i),
        .offset_i          (offset_i),
        .fill_valid_i      (fill_valid_i),
        .fill_index_i      (fill_index_i),
        .fill_tag_i        (fill_tag_i),
        .hit_flag_wren_o   (hit_flag_wren_o),
        .hit_flag_wdata_o  (hit_flag_wdata_o),
        .miss_addr_wren_o  (miss_addr_wren_o),
        .miss_addr_wdata_o (miss_addr_wdata_o),
        .miss_req_wren_o   (miss_req_wren_o),
        .miss_req_wdata_o  (miss_req_wdata_o),
        .data_rden_o       (data_rden_o),
        .data_index_o      (data_index_o),
        .data_offset_o     (data_offset_o),
        .hit_cnt_o         (hit_cnt_o),
        .miss_cnt_o        (miss_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [16:0] t, input logic [8:0] i, input logic [2:0] o);
        hs_pulse_i = 1'b1;
        tag_i      = t;
        index_i    = i;
        offset_i   = o;
    endtask

    task automatic fill(input logic [8:0] i, input logic [16:0] t);
        fill_valid_i = 1'b1;
        fill_index_i = i;
        fill_tag_i   = t;
    endtask

    task automatic idle();
        hs_pulse_i   = 1'b0;
        fill_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] strobes;
        do_reset();
        strobes = {hit_flag_wren_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o, hit_flag_wdata_o};
        checks++;
        if (strobes !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000", strobes);
        end
        checks++;
        if ({miss_addr_wdata_o, miss_req_wdata_o, data_index_o, data_offset_o} !== 67'b0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0", miss_addr_wdata_o, miss_req_wdata_o, data_index_o, data_offset_o);
        end
        checks++;
        if ({hit_cnt_o, miss_cnt_o} !== 64'b0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
        end
    endtask

    task automatic test_miss();
        req(17'h00001, 9'd5, 3'd2);
        tick();
        idle();
        checks++;
        if (hit_flag_wren_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_early got %b want 0", hit_flag_wren_o);
        end
        tick();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o} !== 5'b10110) begin
            errors++;
            $display("FAIL miss_strobes got %b want 10110", {hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o});
        end
        checks++;
        if (miss_addr_wdata_o !== 29'h0000102A) begin
            errors++;
            $display("FAIL miss_addr got %h want 0000102a", miss_addr_wdata_o);
        end
        checks++;
        if (miss_req_wdata_o !== 26'h205) begin
            errors++;
            $display("FAIL miss_req got %h want 205", miss_req_wdata_o);
        end
        tick();
        checks++;
        if ({hit_flag_wren_o, miss_addr_wren_o, miss_req_wren_o} !== 3'b000) begin
            errors++;
            $display("FAIL miss_one_cycle got %b want 000", {hit_flag_wren_o, miss_addr_wren_o, miss_req_wren_o});
        end
    endtask

    task automatic test_fill_hit();
        fill(9'd5, 17'h00001);
        tick();
        idle();
        tick();
        tick();
        req(17'h00001, 9'd5, 3'd2);
        tick();
        idle();
        tick();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o} !== 5'b11001) begin
            errors++;
            $display("FAIL hit_strobes got %b want 11001", {hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o});
        end
        checks++;
        if ({data_index_o, data_offset_o} !== {9'd5, 3'd2}) begin
            errors++;
            $display("FAIL hit_data got %0d/%0d want 5/2", data_index_o, data_offset_o);
        end
        tick();
        checks++;
        if ({hit_flag_wren_o, data_rden_o} !== 2'b00) begin
            errors++;
            $display("FAIL hit_one_cycle got %b want 00", {hit_flag_wren_o, data_rden_o});
        end
    endtask

    task automatic test_forward();
        fill(9'd7, 17'h1AAAA);
        tick();
        idle();
        tick();
        req(17'h05555, 9'd7, 3'd1);
        fill(9'd7, 17'h05555);
        tick();
        idle();
        tick();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o} !== 4'b1110) begin
            errors++;
            $display("FAIL fwd_same_cycle got %b want 1110", {hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o});
        end
        req(17'h0F0F0, 9'd7, 3'd4);
        tick();
        idle();
        fill(9'd7, 17'h0F0F0);
        tick();
        idle();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o} !== 4'b1110) begin
            errors++;
            $display("FAIL fwd_next_cycle got %b want 1110", {hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o});
        end
        fill(9'd7, 17'h00123);
        req(17'h00456, 9'd7, 3'd0);
        tick();
        idle();
        fill(9'd7, 17'h00456);
        tick();
        idle();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, data_rden_o} !== 3'b111) begin
            errors++;
            $display("FAIL fwd_priority got %b want 111", {hit_flag_wren_o, hit_flag_wdata_o, data_rden_o});
        end
        req(17'h00123, 9'd7, 3'd0);
        tick();
        idle();
        tick();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o} !== 3'b101) begin
            errors++;
            $display("FAIL fwd_stale got %b want 101", {hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o});
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        do_reset();
        for (int i = 0; i < 512; i += 2) begin
            fill(i[8:0], 17'h00100 + 17'(i));
            tick();
        end
        idle();
        tick();
        bad = 0;
        for (int c = 0; c <= 512; c++) begin
            if (c < 512) req(17'h00100 + 17'(c), c[8:0], 3'(c));
            else idle();
            tick();
            if (c >= 1) begin
                logic even;
                int n;
                n = c - 1;
                even = (n % 2) == 0;
                checks++;
                if ({hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o, miss_req_wren_o, data_index_o} !==
                    {1'b1, even, even, !even, !even, 9'(n)}) begin
                    errors++;
                    bad++;
                    if (bad < 5) $display("FAIL b2b_%0d got %b%b%b%b%b idx %0d want 1%b%b%b%b idx %0d",
                        n, hit_flag_wren_o, hit_flag_wdata_o, data_rden_o, miss_addr_wren_o, miss_req_wren_o,
                        data_index_o, even, even, !even, !even, n);
                end
            end
        end
        tick();
        checks++;
        if (hit_flag_wren_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got %b want 0", hit_flag_wren_o);
        end
    endtask

    task automatic test_reset_midflight();
        req(17'h00100, 9'd0, 3'd0);
        tick();
        req(17'h00102, 9'd2, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({hit_flag_wren_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_flush_%0d got %b want 0000", k, {hit_flag_wren_o, miss_addr_wren_o, miss_req_wren_o, data_rden_o});
            end
            tick();
        end
        req(17'h00100, 9'd0, 3'd0);
        tick();
        idle();
        tick();
        checks++;
        if ({hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, data_rden_o} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_invalidates got %b want 1010", {hit_flag_wren_o, hit_flag_wdata_o, miss_addr_wren_o, data_rden_o});
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
`ifdef CC_TAG_STAT_EN
        exp_hit  = 32'd3;
        exp_miss = 32'd2;
`else
        exp_hit  = 32'd0;
        exp_miss = 32'd0;
`endif
        do_reset();
        for (int i = 10; i < 13; i++) begin
            fill(i[8:0], 17'h00077);
            tick();
        end
        idle();
        tick();
        for (int i = 10; i < 15; i++) begin
            req(17'h00077, i[8:0], 3'd0);
            tick();
        end
        idle();
        tick();
        tick();
        checks++;
        if (hit_cnt_o !== exp_hit) begin
            errors++;
            $display("FAIL hit_cnt got %0d want %0d", hit_cnt_o, exp_hit);
        end
        checks++;
        if (miss_cnt_o !== exp_miss) begin
            errors++;
            $display("FAIL miss_cnt got %0d want %0d", miss_cnt_o, exp_miss);
        end
    endtask

    initial begin
        rst          = 1'b1;
        hs_pulse_i   = 1'b0;
        tag_i        = '0;
        index_i      = '0;
        offset_i     = '0;
        fill_valid_i = 1'b0;
        fill_index_i = '0;
        fill_tag_i   = '0;
        tick();
        test_reset();
        test_miss();
        test_fill_hit();
        test_forward();
        test_back_to_back();
        test_reset_midflight();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
